// File: rtl/timer_pkg.sv
// Shared types for the timer/interrupt bank: channel mode and FSM state
// encodings, plus the channel-index width helper.
package timer_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } ch_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // A single-channel build still needs a 1-bit index port.
  function automatic int CH_IDX_W(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/timer_irq_bank_if.sv
// Configuration / interrupt bus of the timer bank. The master (core side)
// drives config and ack; the slave (timer bank) returns tick/pending/irq/running.
interface timer_irq_bank_if
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
);
  localparam int IDX_W = CH_IDX_W(NUM_CH);

  // cfg_we is a single-cycle write strobe with no back-pressure: the bank
  // accepts every write on the clock edge where cfg_we is high.
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]   cfg_limit;
  logic               cfg_en;
  logic               cfg_oneshot;
  logic [PRESC_W-1:0] presc_div;
  logic [NUM_CH-1:0]  irq_ack;

  logic [NUM_CH-1:0]  tick;
  logic [NUM_CH-1:0]  irq_pending;
  logic               irq;
  logic [NUM_CH-1:0]  running;

  modport master (
    output cfg_we, cfg_ch, cfg_limit, cfg_en, cfg_oneshot, presc_div, irq_ack,
    input  tick, irq_pending, irq, running
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_limit, cfg_en, cfg_oneshot, presc_div, irq_ack,
    output tick, irq_pending, irq, running
  );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: up-counter to a programmable limit, IDLE/RUN FSM,
// registered tick pulse and sticky pending flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             cfg_en,
  input  logic             cfg_oneshot,
  input  logic             ack,
  output logic             tick,
  output logic             pending,
  output logic             running
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_e        state_q, state_d;
  ch_mode_e         mode_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] limit_q;
  logic             tick_q;
  logic             pending_q;
  logic             expire;
  logic             fire;

  // In RUN the limit is never zero, so limit_q - 1 cannot wrap.
  assign expire = (state_q == ST_RUN) && adv && (count_q == (limit_q - ONE));
  assign fire   = expire && !cfg_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_wr) begin
      state_d = (cfg_en && (cfg_limit != '0)) ? ST_RUN : ST_IDLE;
    end else if (expire && (mode_q == MODE_ONESHOT)) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    running = (state_q == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      limit_q   <= '0;
      mode_q    <= MODE_PERIODIC;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      tick_q    <= fire;
      // A new expiry beats a same-cycle ack.
      pending_q <= fire | (pending_q & ~ack);
      if (cfg_wr) begin
        limit_q <= cfg_limit;
        mode_q  <= cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
        count_q <= '0;
      end else if ((state_q == ST_RUN) && adv) begin
        count_q <= expire ? '0 : (count_q + ONE);
      end
    end
  end

  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: rtl/timer_irq_bank.sv
// Multi-channel timer/interrupt bank: config decode, shared prescaler and
// the ORed irq register around NUM_CH timer_channel instances.
// Optional feature macro: TIMER_PRESCALE_EN (shared clock prescaler).
module timer_irq_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  timer_irq_bank_if.slave bus
);

  localparam int IDX_W = CH_IDX_W(NUM_CH);

  logic              adv;
  logic [NUM_CH-1:0] wr_v;
  logic [NUM_CH-1:0] tick_v;
  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] run_v;
  logic              irq_q;

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q;
  logic               presc_wrap;

  assign presc_wrap = (presc_q == bus.presc_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_wrap ? '0 : (presc_q + PRESC_W'(1));
    end
  end

  assign adv = presc_wrap;
`else
  assign adv = 1'b1;
`endif

  // Out-of-range channel indices match no channel and are dropped.
  always_comb begin
    wr_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_v[i] = bus.cfg_we && (bus.cfg_ch == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .cfg_wr     (wr_v[g]),
      .cfg_limit  (bus.cfg_limit),
      .cfg_en     (bus.cfg_en),
      .cfg_oneshot(bus.cfg_oneshot),
      .ack        (bus.irq_ack[g]),
      .tick       (tick_v[g]),
      .pending    (pend_v[g]),
      .running    (run_v[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |pend_v;
    end
  end

  assign bus.tick        = tick_v;
  assign bus.irq_pending = pend_v;
  assign bus.irq         = irq_q;
  assign bus.running     = run_v;

endmodule
